// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the four-port round-robin memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned NUM_REQ          = 4;
    localparam int unsigned SEL_W            = 2;
    localparam int          DEFAULT_MAX_HOLD = 16;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        sel_onehot    = '0;
        sel_onehot[s] = 1'b1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin pick: first set request scanning upward (mod 4) from start.
module rr_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   start,
    output logic               found,
    output logic [SEL_W-1:0]   winner
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = start;
        idx    = start;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = start + SEL_W'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/mux4.sv
// Generic 4:1 word multiplexer.
module mux4 #(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [W-1:0] y
);

    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of a shared 32-bit port for four requesters, no preemption.
// Define ARB_TIMEOUT_EN to compile in the MAX_HOLD grant-hold timeout and timeout port.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N = 32
`ifdef ARB_TIMEOUT_EN
    , parameter int MAX_HOLD = DEFAULT_MAX_HOLD
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [N-1:0]       in_0,
    input  logic [N-1:0]       in_1,
    input  logic [N-1:0]       in_2,
    input  logic [N-1:0]       in_3,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic [N-1:0]       out,
    output logic               busy
`ifdef ARB_TIMEOUT_EN
    , output logic             timeout
`endif
);

    arb_state_t         state, state_nx;
    logic [NUM_REQ-1:0] gnt_nx;
    logic [SEL_W-1:0]   sel_nx, last, last_nx;
    logic [NUM_REQ-1:0] req_ok, pick_req;
    logic [SEL_W-1:0]   pick_start, pick_winner, mux_sel;
    logic               pick_found, grant_edge, hold_hit;

`ifdef ARB_TIMEOUT_EN
    logic [7:0]         hold_cnt, hold_cnt_nx;
    logic [NUM_REQ-1:0] mask, mask_nx;
    logic               timeout_nx;

    assign req_ok   = req & ~mask;
    assign hold_hit = (state == OWN) && req[sel] && (hold_cnt == 8'(MAX_HOLD - 1));
`else
    assign req_ok   = req;
    assign hold_hit = 1'b0;
`endif

    rr_pick u_pick (
        .req    (pick_req),
        .start  (pick_start),
        .found  (pick_found),
        .winner (pick_winner)
    );

    // One picker serves both IDLE arbitration (from last+1) and handover (from sel+1).
    always_comb begin
        state_nx   = state;
        gnt_nx     = gnt;
        sel_nx     = sel;
        last_nx    = last;
        pick_req   = req_ok;
        pick_start = last + 2'd1;
        grant_edge = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_nx = hold_cnt;
        mask_nx     = mask & req;
        timeout_nx  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (pick_found) grant_edge = 1'b1;
            end
            OWN: begin
                pick_start = sel + 2'd1;
                pick_req   = req_ok & ~sel_onehot(sel);
                if (!req[sel] || hold_hit) begin
`ifdef ARB_TIMEOUT_EN
                    if (hold_hit) begin
                        timeout_nx   = 1'b1;
                        mask_nx[sel] = 1'b1;
                    end
`endif
                    if (pick_found) begin
                        grant_edge = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        gnt_nx   = '0;
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_nx = hold_cnt + 8'd1;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
        if (grant_edge) begin
            state_nx = OWN;
            gnt_nx   = sel_onehot(pick_winner);
            sel_nx   = pick_winner;
            last_nx  = pick_winner;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_nx = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            last  <= 2'd3;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
            mask     <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            gnt   <= gnt_nx;
            sel   <= sel_nx;
            last  <= last_nx;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt_nx;
            mask     <= mask_nx;
            timeout  <= timeout_nx;
`endif
        end
    end

    assign busy    = |gnt;
    assign mux_sel = busy ? sel : '0;

    mux4 #(.W(N)) u_mux (
        .sel (mux_sel),
        .d0  (in_0),
        .d1  (in_1),
        .d2  (in_2),
        .d3  (in_3),
        .y   (out)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a round-robin reference model.
module tb_mem_port_arbiter;

    localparam int N = 32;
`ifdef ARB_TIMEOUT_EN
    localparam int HOLD  = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int HOLD  = 0;
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [N-1:0] in_w [4];
    logic [N-1:0] in_0, in_1, in_2, in_3;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [N-1:0] out;
    logic         busy;
    logic         timeout;

    assign in_0 = in_w[0];
    assign in_1 = in_w[1];
    assign in_2 = in_w[2];
    assign in_3 = in_w[3];

    always #5 clk = ~clk;

`ifdef ARB_TIMEOUT_EN
    mem_port_arbiter #(.N(N), .MAX_HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .req(req),
        .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
        .gnt(gnt), .sel(sel), .out(out), .busy(busy), .timeout(timeout)
    );
`else
    mem_port_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst), .req(req),
        .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
        .gnt(gnt), .sel(sel), .out(out), .busy(busy)
    );
    assign timeout = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner index (-1 = idle), pointer, cycles held, masks.
    int m_owner, m_last, m_sel, m_held;
    bit m_mask [4];
    bit m_to;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int scan(input logic [3:0] cand, input int from);
        for (int i = 0; i < 4; i++) begin
            int j;
            j = (from + i) % 4;
            if (cand[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_sel   = 0;
        m_held  = 0;
        m_to    = 1'b0;
        for (int i = 0; i < 4; i++) m_mask[i] = 1'b0;
    endtask

    task automatic model_grant(input int w);
        m_owner = w;
        m_last  = w;
        m_sel   = w;
        m_held  = 1;
    endtask

    task automatic model_edge();
        logic [3:0] elig;
        int         nxt, prev;
        bit         forced;
        elig   = req;
        forced = 1'b0;
        prev   = 0;
        for (int i = 0; i < 4; i++) if (m_mask[i]) elig[i] = 1'b0;
        if (m_owner < 0) begin
            nxt = scan(elig, m_last + 1);
            if (nxt >= 0) model_grant(nxt);
        end else if (!req[m_owner] || (TO_EN && m_held == HOLD)) begin
            prev       = m_owner;
            forced     = req[m_owner];
            elig[prev] = 1'b0;
            nxt        = scan(elig, prev + 1);
            if (nxt >= 0) model_grant(nxt);
            else m_owner = -1;
        end else begin
            m_held++;
        end
        for (int i = 0; i < 4; i++) if (!req[i]) m_mask[i] = 1'b0;
        if (forced) m_mask[prev] = 1'b1;
        m_to = forced;
    endtask

    task automatic compare_all();
        logic [3:0]   exp_gnt;
        logic [N-1:0] exp_out;
        exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        exp_out = (m_owner < 0) ? in_w[0] : in_w[m_sel];
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("sel", 32'(sel), 32'(m_sel));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("out", out, exp_out);
        check("timeout", 32'(timeout), 32'(m_to));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        req = 4'b0000;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        check("rst_gnt", 32'(gnt), 32'd0);
        rst = 1'b0;
    endtask

    task automatic randomize_words();
        for (int i = 0; i < 4; i++) in_w[i] = $urandom;
    endtask

    initial begin
        req = 4'b0000;
        rst = 1'b0;
        randomize_words();
        model_reset();
        #2;
        apply_reset();

        // Single requester grant and release
        req = 4'b0100;
        step();
        check("t1_gnt", 32'(gnt), 32'h4);
        check("t1_sel", 32'(sel), 32'd2);
        check("t1_out", out, in_w[2]);
        req = 4'b0000;
        step();
        check("t1_idle_gnt", 32'(gnt), 32'd0);
        check("t1_idle_busy", 32'(busy), 32'd0);

        // All requesting: owner drops for one cycle after its grant
        apply_reset();
        req = 4'b1111;
        step();
        check("t2_first", 32'(gnt), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            logic [3:0] drop;
            logic [3:0] want;
            drop = 4'b0001 << ((k - 1) % 4);
            want = 4'b0001 << (k % 4);
            req  = 4'b1111 & ~drop;
            step();
            check("t2_order", 32'(gnt), 32'(want));
        end

        // Owner 1 holds while requester 3 waits
        apply_reset();
        req = 4'b0010;
        step();
        req = 4'b1010;
        for (int k = 0; k < 10; k++) begin
            step();
`ifndef ARB_TIMEOUT_EN
            check("t3_hold", 32'(gnt), 32'h2);
`endif
        end
        req = 4'b1000;
        step();
`ifndef ARB_TIMEOUT_EN
        check("t3_handover", 32'(gnt), 32'h8);
`endif

        // Asynchronous reset mid-grant
        apply_reset();
        req = 4'b0010;
        step();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check("t4_gnt", 32'(gnt), 32'd0);
        check("t4_sel", 32'(sel), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'b0011;
        step();
        check("t4_regrant", 32'(gnt), 32'h1);

        // Stuck requester 0 with requester 2 waiting
        apply_reset();
        req = 4'b0101;
        step();
        check("t5_first", 32'(gnt), 32'h1);
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < HOLD - 1; k++) begin
            step();
            check("t5_hold", 32'(gnt), 32'h1);
        end
        step();
        check("t5_to_gnt", 32'(gnt), 32'h4);
        check("t5_to_pulse", 32'(timeout), 32'd1);
        req = 4'b0001;
        step();
        check("t5_pulse_end", 32'(timeout), 32'd0);
        step();
        check("t5_masked", 32'(gnt), 32'd0);
        req = 4'b0000;
        step();
        req = 4'b0001;
        step();
        check("t5_unmasked", 32'(gnt), 32'h1);
`else
        for (int k = 0; k < 100; k++) begin
            step();
            check("t5_hold", 32'(gnt), 32'h1);
        end
`endif

        // Random traffic with occasional asynchronous reset
        apply_reset();
        for (int k = 0; k < 800; k++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            randomize_words();
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst = 1'b1;
                model_reset();
                #1;
                compare_all();
                @(posedge clk);
                #1;
                rst = 1'b0;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
